// File: rtl/store_bus_checker.sv
// store_bus_checker
// Watches the data-memory store bus of the pipelined MIPS top and checks every
// qualifying store, in order, against a programmable table of expected
// (address, data) pairs. The result is reported as sticky pass / fail / timeout
// flags, with the first offending store captured for debug or LED display.

module store_bus_checker #(
  parameter int          DEPTH       = 8,
  parameter int          IDX_W       = 3,
  parameter int          TIMEOUT     = 1000,
  parameter bit          IGNORE_EN   = 1'b1,
  parameter logic [31:0] IGNORE_ADDR = 32'd80
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_memwrite,
  input  logic [31:0]      i_dataadr,
  input  logic [31:0]      i_writedata,
  input  logic             i_cfg_we,
  input  logic [IDX_W-1:0] i_cfg_idx,
  input  logic [31:0]      i_cfg_addr,
  input  logic [31:0]      i_cfg_data,
  input  logic [IDX_W:0]   i_cfg_len,
  input  logic             i_cfg_start,
  output logic             o_busy,
  output logic             o_pass,
  output logic             o_fail,
  output logic             o_timeout,
  output logic             o_done,
  output logic [IDX_W:0]   o_match_cnt,
  output logic [IDX_W-1:0] o_err_idx,
  output logic [31:0]      o_err_addr,
  output logic [31:0]      o_err_data
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0]   LEN_MAX = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   LEN_ONE = (IDX_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TOUT
  } state_t;

  // Status flag bundle {busy, pass, fail, timeout, done}, registered with the state.
  function automatic logic [4:0] flagsOf(input state_t s);
    logic [4:0] f;
    f = 5'b0;
    case (s)
      S_RUN:   f = 5'b10000;
      S_PASS:  f = 5'b01001;
      S_FAIL:  f = 5'b00101;
      S_TOUT:  f = 5'b00011;
      default: f = 5'b00000;
    endcase
    return f;
  endfunction

  state_t           r_state;
  logic [4:0]       r_flags;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W:0]   r_len;
  logic [CNT_W-1:0] r_cycleCnt;
  logic [IDX_W:0]   r_matchCnt;
  logic [IDX_W-1:0] r_errIdx;
  logic [31:0]      r_errAddr;
  logic [31:0]      r_errData;

  logic [31:0]      r_tabAddr [DEPTH];
  logic [31:0]      r_tabData [DEPTH];

  logic [IDX_W:0]   w_runLen;
  logic             w_store;
  logic             w_hit;
  logic             w_last;
  logic             w_matchEnd;
  logic             w_mismatch;

  // Clamp the requested length to the table size; detect the store that
  // counts, whether it matches the current entry, and whether it is the last.
  always_comb begin
    w_runLen   = (i_cfg_len > LEN_MAX) ? LEN_MAX : i_cfg_len;
    w_store    = i_memwrite && !(IGNORE_EN && (i_dataadr == IGNORE_ADDR));
    w_hit      = (i_dataadr == r_tabAddr[r_idx]) && (i_writedata == r_tabData[r_idx]);
    w_last     = ({1'b0, r_idx} == (r_len - LEN_ONE));
    w_matchEnd = w_store && w_hit && w_last;
    w_mismatch = w_store && !w_hit;
  end

  // Expected-store table: writable whenever a run is not in progress, and
  // deliberately left out of reset so a rerun after reset needs no reload.
  always_ff @(posedge i_clk) begin
    if (i_cfg_we && (r_state != S_RUN)) begin
      r_tabAddr[i_cfg_idx] <= i_cfg_addr;
      r_tabData[i_cfg_idx] <= i_cfg_data;
    end
  end

  // Checker FSM: arms on cfg_start, walks the table on each counted store and
  // parks in a sticky terminal state; a compare outcome beats the timeout.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_flags    <= 5'b0;
      r_idx      <= '0;
      r_len      <= '0;
      r_cycleCnt <= '0;
      r_matchCnt <= '0;
      r_errIdx   <= '0;
      r_errAddr  <= '0;
      r_errData  <= '0;
    end else if (r_state == S_RUN) begin
      if (w_store && w_hit) begin
        r_matchCnt <= r_matchCnt + LEN_ONE;
        if (!w_last) begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_mismatch) begin
        r_errIdx  <= r_idx;
        r_errAddr <= i_dataadr;
        r_errData <= i_writedata;
      end
      if (w_matchEnd) begin
        r_state <= S_PASS;
        r_flags <= flagsOf(S_PASS);
      end else if (w_mismatch) begin
        r_state <= S_FAIL;
        r_flags <= flagsOf(S_FAIL);
      end else if (r_cycleCnt == CNT_END) begin
        r_state <= S_TOUT;
        r_flags <= flagsOf(S_TOUT);
      end else begin
        r_cycleCnt <= r_cycleCnt + CNT_ONE;
      end
    end else if (i_cfg_start) begin
      r_len      <= w_runLen;
      r_idx      <= '0;
      r_cycleCnt <= '0;
      r_matchCnt <= '0;
      r_errIdx   <= '0;
      r_errAddr  <= '0;
      r_errData  <= '0;
      if (w_runLen == '0) begin
        r_state <= S_PASS;
        r_flags <= flagsOf(S_PASS);
      end else begin
        r_state <= S_RUN;
        r_flags <= flagsOf(S_RUN);
      end
    end
  end

  assign o_busy      = r_flags[4];
  assign o_pass      = r_flags[3];
  assign o_fail      = r_flags[2];
  assign o_timeout   = r_flags[1];
  assign o_done      = r_flags[0];
  assign o_match_cnt = r_matchCnt;
  assign o_err_idx   = r_errIdx;
  assign o_err_addr  = r_errAddr;
  assign o_err_data  = r_errData;

endmodule

// File: doc/store_bus_checker.md
Name: store_bus_checker

Overview:
- Synthesizable self-checking monitor on the data-memory store bus (memwrite, dataadr, writedata) driven by the pipelined MIPS top.
- Compares every qualifying store, in order, against a programmable table of expected (address, data) pairs.
- Reports pass / fail / timeout with error capture.
- Replaces ad-hoc per-program negedge checks in per-instruction benches; also usable on FPGA with status on LEDs.

Parameters:
DEPTH, 8, number of expected-store table entries
IDX_W, 3, index width, equal to clog2(DEPTH)
TIMEOUT, 1000, RUN cycles allowed before declaring timeout
IGNORE_EN, 1, 1 = stores to IGNORE_ADDR are skipped, not compared
IGNORE_ADDR, 80, address of filler/scratch stores excluded from checking

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
memwrite  in  1  store strobe from top
dataadr  in  32  store address from top
writedata  in  32  store data from top
cfg_we  in  1  write expected entry
cfg_idx  in  IDX_W  table entry index
cfg_addr  in  32  expected address
cfg_data  in  32  expected data
cfg_len  in  IDX_W+1  number of entries to check
cfg_start  in  1  arm checker (pulse)
busy  out  1  state == RUN
pass  out  1  all entries matched (sticky)
fail  out  1  mismatch detected (sticky)
timeout  out  1  TIMEOUT exceeded (sticky)
done  out  1  pass | fail | timeout
match_cnt  out  IDX_W+1  entries matched so far
err_idx  out  IDX_W  table index at first mismatch
err_addr  out  32  offending store address
err_data  out  32  offending store data

Behaviour:
- Reset (sync, active-high):
  - State = IDLE.
  - All outputs 0; internal idx, len, cycle counter = 0.
  - Table contents not reset and preserved across reset.
- States: IDLE, RUN, PASS, FAIL, TOUT. Outputs registered; every status change is visible 1 cycle after the sampling edge.
- Configuration:
  - cfg_we writes table[cfg_idx] in any state except RUN; ignored in RUN.
  - cfg_start in any state except RUN:
    - len = min(cfg_len, DEPTH); clear match_cnt, err_*, cycle counter, pass/fail/timeout.
    - If len == 0, go to PASS; otherwise go to RUN with idx = 0.
  - cfg_start in RUN is ignored.
  - cfg_we and cfg_start in the same cycle: the entry write completes first and is used by the run.
- RUN, on each cycle with memwrite == 1:
  - If IGNORE_EN and dataadr == IGNORE_ADDR: skip; no count, no compare.
  - Else if dataadr == table[idx].addr and writedata == table[idx].data:
    - match_cnt++, idx++.
    - If idx == len-1 (last entry), go to PASS.
  - Else go to FAIL; capture err_idx = idx, err_addr = dataadr, err_data = writedata.
- Cycles with memwrite == 0 do nothing except the timeout count.
- Timeout:
  - Cycle counter increments every RUN cycle.
  - When it reaches TIMEOUT-1 with no terminal event, go to TOUT.
  - A compare outcome (PASS/FAIL) in the same cycle takes priority over timeout.
- PASS / FAIL / TOUT are sticky:
  - Further stores are ignored; match_cnt and err_* are frozen.
  - Leave only via reset or cfg_start.
- Output mapping:
  - busy = RUN; pass = PASS; fail = FAIL; timeout = TOUT.
  - done = any terminal state; exactly one of pass/fail/timeout is high when done.
- Reset mid-RUN: IDLE next cycle, status cleared, table retained. A subsequent cfg_start reruns without reloading.
- Arithmetic: equality compares are exact on all 32 bits. Counters are unsigned and cannot wrap, because len ≤ DEPTH and the cycle counter saturates at the terminal transition.

Test Plan:
1. Load table[0] = (84, 7), cfg_len = 1, start; drive stores (80, 3), then (84, 7) -> the (80, 3) store is ignored; pass = 1, done = 1, match_cnt = 1, one cycle after the (84, 7) edge.
2. Same table; drive store (84, 6) -> fail = 1, err_idx = 0, err_addr = 84, err_data = 6; a following (84, 7) leaves fail = 1 and match_cnt = 0.
3. Load (0x10, 1), (0x14, 2), (0x18, 3), len = 3; drive 0x10/1, 80/x, 0x14/2, idle cycles, 0x18/3 -> pass after the third counted store, match_cnt = 3. Reversed order -> fail, err_idx = 0.
4. TIMEOUT = 20, len = 1, no memwrite -> timeout = 1 exactly 20 cycles after the start edge. Matching store on the final cycle -> pass, not timeout.
5. Start len = 2, match entry 0, assert reset 1 cycle -> all status 0, busy = 0; restart with cfg_start only and drive both stores -> pass (table retained).
6. cfg_len = 0 -> pass next cycle. cfg_start and cfg_we asserted during RUN -> no effect on state or table.
